// File: rtl/writeback_stage_if.sv
// Writeback-stage bus: retiring-instruction inputs from execute/memory and
// the register-file write port driven back out.
interface writeback_stage_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_THREADS    = 16,
  parameter int REG_ADDR_WIDTH = 5
) ();
  localparam int TID_W = $clog2(NUM_THREADS);

  logic                      i_valid;
  logic [TID_W-1:0]          i_thread_id;
  logic [REG_ADDR_WIDTH-1:0] i_rd;
  logic                      i_reg_we;
  logic [1:0]                i_wb_sel;
  logic [2:0]                i_funct3;
  logic [DATA_WIDTH-1:0]     i_alu_result;
  logic [DATA_WIDTH-1:0]     i_pc_plus4;
  logic [DATA_WIDTH-1:0]     i_load_word;

  logic                      o_valid;
  logic [TID_W-1:0]          o_thread_id;
  logic [REG_ADDR_WIDTH-1:0] o_rd;
  logic                      o_we;
  logic [DATA_WIDTH-1:0]     o_wdata;
  logic                      o_err;

  modport master (
    output i_valid, i_thread_id, i_rd, i_reg_we, i_wb_sel, i_funct3,
           i_alu_result, i_pc_plus4, i_load_word,
    input  o_valid, o_thread_id, o_rd, o_we, o_wdata, o_err
  );

  modport slave (
    input  i_valid, i_thread_id, i_rd, i_reg_we, i_wb_sel, i_funct3,
           i_alu_result, i_pc_plus4, i_load_word,
    output o_valid, o_thread_id, o_rd, o_we, o_wdata, o_err
  );
endinterface

// File: rtl/writeback_stage.sv
// Two-stage writeback unit: S1 registers the retiring instruction, S2 merges
// it with the late-arriving memory word, extracts load data, picks the
// writeback source and drives the hart-tagged register-file write port.
module writeback_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_THREADS    = 16,
  parameter int REG_ADDR_WIDTH = 5
) (
  input logic             i_clk,
  input logic             i_rst_n,
  writeback_stage_if.slave bus
);
  localparam int TID_W = $clog2(NUM_THREADS);

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10,
    WB_ILL  = 2'b11
  } wb_sel_e;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_f3_e;

  // S1 state
  logic                      s1_valid_d, s1_valid_q;
  logic [TID_W-1:0]          s1_tid_d, s1_tid_q;
  logic [REG_ADDR_WIDTH-1:0] s1_rd_d, s1_rd_q;
  logic                      s1_we_d, s1_we_q;
  wb_sel_e                   s1_sel_d, s1_sel_q;
  load_f3_e                  s1_f3_d, s1_f3_q;
  logic [1:0]                s1_off_d, s1_off_q;
  logic [DATA_WIDTH-1:0]     s1_alu_d, s1_alu_q;
  logic [DATA_WIDTH-1:0]     s1_pc_d, s1_pc_q;

  // S2 (output) state
  logic                      o_valid_d, o_valid_q;
  logic [TID_W-1:0]          o_tid_d, o_tid_q;
  logic [REG_ADDR_WIDTH-1:0] o_rd_d, o_rd_q;
  logic                      o_we_d, o_we_q;
  logic [DATA_WIDTH-1:0]     o_wdata_d, o_wdata_q;
  logic                      o_err_d, o_err_q;

  // S2 datapath temporaries
  logic [7:0]            byte_v;
  logic [15:0]           half_v;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_bad;
  logic                  err;

  // S1 next state: straight capture of the retiring instruction
  always_comb begin
    s1_valid_d = bus.i_valid;
    s1_tid_d   = bus.i_thread_id;
    s1_rd_d    = bus.i_rd;
    s1_we_d    = bus.i_reg_we;
    s1_sel_d   = wb_sel_e'(bus.i_wb_sel);
    s1_f3_d    = load_f3_e'(bus.i_funct3);
    s1_off_d   = bus.i_alu_result[1:0];
    s1_alu_d   = bus.i_alu_result;
    s1_pc_d    = bus.i_pc_plus4;
  end

  // S1 register with synchronous flush
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_tid_q   <= '0;
      s1_rd_q    <= '0;
      s1_we_q    <= 1'b0;
      s1_sel_q   <= WB_ALU;
      s1_f3_q    <= F3_LB;
      s1_off_q   <= '0;
      s1_alu_q   <= '0;
      s1_pc_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_tid_q   <= s1_tid_d;
      s1_rd_q    <= s1_rd_d;
      s1_we_q    <= s1_we_d;
      s1_sel_q   <= s1_sel_d;
      s1_f3_q    <= s1_f3_d;
      s1_off_q   <= s1_off_d;
      s1_alu_q   <= s1_alu_d;
      s1_pc_q    <= s1_pc_d;
    end
  end

  // S2 next state: load extraction, error detection, source select, gating
  always_comb begin
    unique case (s1_off_q)
      2'd0:    byte_v = bus.i_load_word[7:0];
      2'd1:    byte_v = bus.i_load_word[15:8];
      2'd2:    byte_v = bus.i_load_word[23:16];
      default: byte_v = bus.i_load_word[31:24];
    endcase
    half_v = s1_off_q[1] ? bus.i_load_word[31:16] : bus.i_load_word[15:0];

    load_data = '0;
    load_bad  = 1'b0;
    case (s1_f3_q)
      F3_LB:  load_data = {{(DATA_WIDTH-8){byte_v[7]}}, byte_v};
      F3_LBU: load_data = {{(DATA_WIDTH-8){1'b0}}, byte_v};
      F3_LH: begin
        load_bad  = s1_off_q[0];
        load_data = {{(DATA_WIDTH-16){half_v[15]}}, half_v};
      end
      F3_LHU: begin
        load_bad  = s1_off_q[0];
        load_data = {{(DATA_WIDTH-16){1'b0}}, half_v};
      end
      F3_LW: begin
        load_bad  = (s1_off_q != 2'b00);
        load_data = bus.i_load_word;
      end
      default: load_bad = 1'b1;
    endcase

    err = s1_valid_q &&
          ((s1_sel_q == WB_ILL) || ((s1_sel_q == WB_LOAD) && load_bad));

    o_wdata_d = '0;
    if (s1_valid_q && !err) begin
      case (s1_sel_q)
        WB_ALU:  o_wdata_d = s1_alu_q;
        WB_LOAD: o_wdata_d = load_data;
        WB_PC4:  o_wdata_d = s1_pc_q;
        default: o_wdata_d = '0;
      endcase
    end

    o_valid_d = s1_valid_q;
    o_err_d   = err;
    o_we_d    = s1_valid_q && s1_we_q && (s1_rd_q != '0) && !err;
    o_tid_d   = s1_valid_q ? s1_tid_q : '0;
    o_rd_d    = s1_valid_q ? s1_rd_q : '0;
  end

  // Output register with synchronous flush
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_valid_q <= 1'b0;
      o_tid_q   <= '0;
      o_rd_q    <= '0;
      o_we_q    <= 1'b0;
      o_wdata_q <= '0;
      o_err_q   <= 1'b0;
    end else begin
      o_valid_q <= o_valid_d;
      o_tid_q   <= o_tid_d;
      o_rd_q    <= o_rd_d;
      o_we_q    <= o_we_d;
      o_wdata_q <= o_wdata_d;
      o_err_q   <= o_err_d;
    end
  end

  assign bus.o_valid     = o_valid_q;
  assign bus.o_thread_id = o_tid_q;
  assign bus.o_rd        = o_rd_q;
  assign bus.o_we        = o_we_q;
  assign bus.o_wdata     = o_wdata_q;
  assign bus.o_err       = o_err_q;
endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed and random instruction streams, with
// expected outputs queued at issue time and compared two cycles later.
module tb_writeback_stage;
  localparam int DW = 32;
  localparam int NT = 16;
  localparam int RW = 5;
  localparam int TW = 4;

  typedef struct packed {
    logic          valid;
    logic [TW-1:0] tid;
    logic [RW-1:0] rd;
    logic          we;
    logic [1:0]    sel;
    logic [2:0]    f3;
    logic [DW-1:0] alu;
    logic [DW-1:0] pc;
    logic [DW-1:0] word;
  } op_t;

  typedef struct packed {
    logic          valid;
    logic [TW-1:0] tid;
    logic [RW-1:0] rd;
    logic          we;
    logic          err;
    logic [DW-1:0] wdata;
  } out_t;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  writeback_stage_if #(.DATA_WIDTH(DW), .NUM_THREADS(NT), .REG_ADDR_WIDTH(RW)) bus ();

  writeback_stage #(.DATA_WIDTH(DW), .NUM_THREADS(NT), .REG_ADDR_WIDTH(RW)) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .bus    (bus)
  );

  out_t          sbq[$];
  logic [DW-1:0] pend_word = '0;
  int unsigned   n_checks = 0;
  int unsigned   n_fail = 0;

  function automatic op_t mk_op(input logic v, input logic [TW-1:0] t, input logic [RW-1:0] r,
                                input logic we, input logic [1:0] s, input logic [2:0] f,
                                input logic [DW-1:0] a, input logic [DW-1:0] p,
                                input logic [DW-1:0] w);
    op_t o;
    o.valid = v; o.tid = t; o.rd = r; o.we = we; o.sel = s; o.f3 = f;
    o.alu = a; o.pc = p; o.word = w;
    return o;
  endfunction

  function automatic out_t mk_exp(input logic v, input logic [TW-1:0] t, input logic [RW-1:0] r,
                                  input logic we, input logic err, input logic [DW-1:0] d);
    out_t e;
    e.valid = v; e.tid = t; e.rd = r; e.we = we; e.err = err; e.wdata = d;
    return e;
  endfunction

  // Reference behaviour used for the randomized stream
  function automatic out_t model(input op_t o);
    out_t          r;
    logic [7:0]    b;
    logic [15:0]   h;
    logic [DW-1:0] d;
    logic          bad;
    r = '0;
    if (!o.valid) return r;
    b   = 8'(o.word >> {o.alu[1:0], 3'b000});
    h   = 16'(o.word >> {o.alu[1], 4'b0000});
    d   = '0;
    bad = 1'b0;
    case (o.sel)
      2'b00: d = o.alu;
      2'b10: d = o.pc;
      2'b11: bad = 1'b1;
      default: begin
        case (o.f3)
          3'b000: d = {{24{b[7]}}, b};
          3'b100: d = {24'h0, b};
          3'b001: begin bad = o.alu[0]; d = {{16{h[15]}}, h}; end
          3'b101: begin bad = o.alu[0]; d = {16'h0, h}; end
          3'b010: begin bad = |o.alu[1:0]; d = o.word; end
          default: bad = 1'b1;
        endcase
      end
    endcase
    r.valid = 1'b1;
    r.tid   = o.tid;
    r.rd    = o.rd;
    r.err   = bad;
    r.we    = o.we && (o.rd != '0) && !bad;
    r.wdata = bad ? '0 : d;
    return r;
  endfunction

  function automatic out_t obs();
    return mk_exp(bus.o_valid, bus.o_thread_id, bus.o_rd, bus.o_we, bus.o_err, bus.o_wdata);
  endfunction

  task automatic drive_op(input op_t o);
    bus.i_valid      = o.valid;
    bus.i_thread_id  = o.tid;
    bus.i_rd         = o.rd;
    bus.i_reg_we     = o.we;
    bus.i_wb_sel     = o.sel;
    bus.i_funct3     = o.f3;
    bus.i_alu_result = o.alu;
    bus.i_pc_plus4   = o.pc;
  endtask

  // Advance one cycle, present a new instruction plus the memory word for
  // the previous one, and queue what should emerge two cycles later.
  task automatic issue(input op_t o, input out_t e);
    @(posedge i_clk);
    #1;
    drive_op(o);
    bus.i_load_word = pend_word;
    pend_word = o.word;
    sbq.push_back(e);
  endtask

  function automatic op_t bubble();
    return mk_op(1'b0, '0, '0, 1'b0, 2'b00, 3'b000, '0, '0, DW'($urandom));
  endfunction

  task automatic test_reset;
    out_t got, e;
    i_rst_n = 1'b0;
    drive_op(mk_op(1'b1, 4'd7, 5'd9, 1'b1, 2'b00, 3'b000, 32'hDEAD_BEEF, 32'h0, 32'h0));
    bus.i_load_word = '0;
    repeat (2) @(posedge i_clk);
    #1;
    got = obs(); n_checks++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL reset: got %h, expected 0", got);
    end
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    got = obs(); n_checks++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL reset_release_first: got %h, expected 0", got);
    end
    drive_op(bubble());
    @(posedge i_clk);
    #1;
    got = obs(); e = mk_exp(1'b1, 4'd7, 5'd9, 1'b1, 1'b0, 32'hDEAD_BEEF); n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL reset_release_op: got %h, expected %h", got, e);
    end
  endtask

  task automatic test_alu;
    op_t  ops[$];
    out_t exps[$];
    out_t got, e;
    ops.push_back(mk_op(1'b1, 4'd3, 5'd5, 1'b1, 2'b00, 3'b000, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF));
    exps.push_back(mk_exp(1'b1, 4'd3, 5'd5, 1'b1, 1'b0, 32'h1234_5678));
    ops.push_back(mk_op(1'b1, 4'd1, 5'd7, 1'b0, 2'b00, 3'b111, 32'hAAAA_5555, 32'h4, 32'h0));
    exps.push_back(mk_exp(1'b1, 4'd1, 5'd7, 1'b0, 1'b0, 32'hAAAA_5555));
    ops.push_back(mk_op(1'b1, 4'd15, 5'd31, 1'b1, 2'b10, 3'b000, 32'h3, 32'h0040_0004, 32'h0));
    exps.push_back(mk_exp(1'b1, 4'd15, 5'd31, 1'b1, 1'b0, 32'h0040_0004));
    repeat (2) begin ops.push_back(bubble()); exps.push_back('0); end
    for (int i = 0; i < ops.size(); i++) begin
      issue(ops[i], exps[i]);
      if (sbq.size() == 3) begin
        e = sbq.pop_front(); got = obs(); n_checks++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL alu[%0d]: got v=%b tid=%0d rd=%0d we=%b err=%b wdata=%h, expected v=%b tid=%0d rd=%0d we=%b err=%b wdata=%h",
                   i, got.valid, got.tid, got.rd, got.we, got.err, got.wdata,
                   e.valid, e.tid, e.rd, e.we, e.err, e.wdata);
        end
      end
    end
  endtask

  task automatic test_loads;
    op_t  ops[$];
    out_t exps[$];
    out_t got, e;
    logic [DW-1:0] w;
    w = 32'h80FF_7F01;
    ops.push_back(mk_op(1'b1, 4'd2, 5'd10, 1'b1, 2'b01, 3'b000, 32'h0000_1003, 32'h0, w));
    exps.push_back(mk_exp(1'b1, 4'd2, 5'd10, 1'b1, 1'b0, 32'hFFFF_FF80));
    ops.push_back(mk_op(1'b1, 4'd4, 5'd11, 1'b1, 2'b01, 3'b100, 32'h0000_1001, 32'h0, w));
    exps.push_back(mk_exp(1'b1, 4'd4, 5'd11, 1'b1, 1'b0, 32'h0000_007F));
    ops.push_back(mk_op(1'b1, 4'd6, 5'd12, 1'b1, 2'b01, 3'b001, 32'h0000_1002, 32'h0, w));
    exps.push_back(mk_exp(1'b1, 4'd6, 5'd12, 1'b1, 1'b0, 32'hFFFF_80FF));
    ops.push_back(mk_op(1'b1, 4'd8, 5'd13, 1'b1, 2'b01, 3'b101, 32'h0000_1000, 32'h0, w));
    exps.push_back(mk_exp(1'b1, 4'd8, 5'd13, 1'b1, 1'b0, 32'h0000_7F01));
    ops.push_back(mk_op(1'b1, 4'd10, 5'd14, 1'b1, 2'b01, 3'b010, 32'h0000_1000, 32'h0, w));
    exps.push_back(mk_exp(1'b1, 4'd10, 5'd14, 1'b1, 1'b0, 32'h80FF_7F01));
    repeat (2) begin ops.push_back(bubble()); exps.push_back('0); end
    for (int i = 0; i < ops.size(); i++) begin
      issue(ops[i], exps[i]);
      if (sbq.size() == 3) begin
        e = sbq.pop_front(); got = obs(); n_checks++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL load[%0d]: got v=%b tid=%0d rd=%0d we=%b err=%b wdata=%h, expected v=%b tid=%0d rd=%0d we=%b err=%b wdata=%h",
                   i, got.valid, got.tid, got.rd, got.we, got.err, got.wdata,
                   e.valid, e.tid, e.rd, e.we, e.err, e.wdata);
        end
      end
    end
  endtask

  task automatic test_errors;
    op_t  ops[$];
    out_t exps[$];
    out_t got, e;
    ops.push_back(mk_op(1'b1, 4'd1, 5'd3, 1'b1, 2'b01, 3'b010, 32'h0000_2002, 32'h0, 32'h1111_2222));
    exps.push_back(mk_exp(1'b1, 4'd1, 5'd3, 1'b0, 1'b1, 32'h0));
    ops.push_back(mk_op(1'b1, 4'd5, 5'd4, 1'b1, 2'b01, 3'b001, 32'h0000_2001, 32'h0, 32'h3333_4444));
    exps.push_back(mk_exp(1'b1, 4'd5, 5'd4, 1'b0, 1'b1, 32'h0));
    ops.push_back(mk_op(1'b1, 4'd9, 5'd6, 1'b1, 2'b01, 3'b011, 32'h0000_2000, 32'h0, 32'h5555_6666));
    exps.push_back(mk_exp(1'b1, 4'd9, 5'd6, 1'b0, 1'b1, 32'h0));
    ops.push_back(mk_op(1'b1, 4'd12, 5'd8, 1'b1, 2'b11, 3'b000, 32'hCAFE_0000, 32'h44, 32'h0));
    exps.push_back(mk_exp(1'b1, 4'd12, 5'd8, 1'b0, 1'b1, 32'h0));
    repeat (2) begin ops.push_back(bubble()); exps.push_back('0); end
    for (int i = 0; i < ops.size(); i++) begin
      issue(ops[i], exps[i]);
      if (sbq.size() == 3) begin
        e = sbq.pop_front(); got = obs(); n_checks++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL err[%0d]: got v=%b tid=%0d rd=%0d we=%b err=%b wdata=%h, expected v=%b tid=%0d rd=%0d we=%b err=%b wdata=%h",
                   i, got.valid, got.tid, got.rd, got.we, got.err, got.wdata,
                   e.valid, e.tid, e.rd, e.we, e.err, e.wdata);
        end
      end
    end
  endtask

  task automatic test_x0;
    op_t  ops[$];
    out_t exps[$];
    out_t got, e;
    ops.push_back(mk_op(1'b1, 4'd11, 5'd0, 1'b1, 2'b10, 3'b000, 32'h0, 32'h0000_0100, 32'h0));
    exps.push_back(mk_exp(1'b1, 4'd11, 5'd0, 1'b0, 1'b0, 32'h0000_0100));
    ops.push_back(mk_op(1'b1, 4'd13, 5'd0, 1'b1, 2'b00, 3'b000, 32'h0BAD_F00D, 32'h0, 32'h0));
    exps.push_back(mk_exp(1'b1, 4'd13, 5'd0, 1'b0, 1'b0, 32'h0BAD_F00D));
    repeat (2) begin ops.push_back(bubble()); exps.push_back('0); end
    for (int i = 0; i < ops.size(); i++) begin
      issue(ops[i], exps[i]);
      if (sbq.size() == 3) begin
        e = sbq.pop_front(); got = obs(); n_checks++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL x0[%0d]: got v=%b tid=%0d rd=%0d we=%b err=%b wdata=%h, expected v=%b tid=%0d rd=%0d we=%b err=%b wdata=%h",
                   i, got.valid, got.tid, got.rd, got.we, got.err, got.wdata,
                   e.valid, e.tid, e.rd, e.we, e.err, e.wdata);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    op_t  ops[$];
    out_t got, e;
    op_t  o;
    for (int h = 0; h < NT; h++) begin
      o = mk_op(1'b1, TW'(h), RW'($urandom_range(0, 31)), 1'(($urandom_range(0, 7) != 0)),
                2'($urandom_range(0, 2)), 3'($urandom_range(0, 7)), DW'($urandom),
                DW'($urandom), DW'($urandom));
      if (h % 3 == 0) begin
        o.sel = 2'b01;
        o.f3  = (h % 2 == 0) ? 3'b000 : 3'b101;
      end
      ops.push_back(o);
      if (h % 5 == 4) ops.push_back(bubble());
    end
    ops.push_back(bubble());
    ops.push_back(bubble());
    for (int i = 0; i < ops.size(); i++) begin
      issue(ops[i], model(ops[i]));
      if (sbq.size() == 3) begin
        e = sbq.pop_front(); got = obs(); n_checks++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL b2b[%0d]: got v=%b tid=%0d rd=%0d we=%b err=%b wdata=%h, expected v=%b tid=%0d rd=%0d we=%b err=%b wdata=%h",
                   i, got.valid, got.tid, got.rd, got.we, got.err, got.wdata,
                   e.valid, e.tid, e.rd, e.we, e.err, e.wdata);
        end
      end
    end
  endtask

  task automatic test_reset_flush;
    op_t  ops[$];
    out_t got, e;
    ops.push_back(mk_op(1'b1, 4'd14, 5'd20, 1'b1, 2'b00, 3'b000, 32'h7777_0001, 32'h0, 32'h0));
    ops.push_back(mk_op(1'b1, 4'd15, 5'd21, 1'b1, 2'b01, 3'b010, 32'h0000_3000, 32'h0, 32'h9999_0002));
    for (int i = 0; i < ops.size(); i++) begin
      issue(ops[i], model(ops[i]));
      if (sbq.size() == 3) begin
        e = sbq.pop_front(); got = obs(); n_checks++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL flush_pre[%0d]: got %h, expected %h", i, got, e);
        end
      end
    end
    i_rst_n = 1'b0;
    @(posedge i_clk);
    #1;
    got = obs(); n_checks++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL flush_first: got %h, expected 0", got);
    end
    sbq.delete();
    i_rst_n = 1'b1;
    drive_op(mk_op(1'b1, 4'd6, 5'd22, 1'b1, 2'b00, 3'b000, 32'h0123_4567, 32'h0, 32'h0));
    bus.i_load_word = 32'h9999_0002;
    @(posedge i_clk);
    #1;
    got = obs(); n_checks++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL flush_second: got %h, expected 0", got);
    end
    drive_op(bubble());
    @(posedge i_clk);
    #1;
    got = obs(); e = mk_exp(1'b1, 4'd6, 5'd22, 1'b1, 1'b0, 32'h0123_4567); n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL flush_after_release: got %h, expected %h", got, e);
    end
    pend_word = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_alu();
    test_loads();
    test_errors();
    test_x0();
    test_back_to_back();
    test_reset_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
